// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready pipeline-register chain with bubble compression, flush and a stall counter.
// Optional skid register ahead of slot 0 when PIPE_SKID_BUF_EN is defined.
module pipe_stage_chain #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       up_valid,
   output logic                       up_ready,
   input  logic [DATA_W-1:0]          up_data,
   input  logic [ADDR_W-1:0]          up_wd,
   input  logic                       up_wreg,
   output logic                       dn_valid,
   input  logic                       dn_ready,
   output logic [DATA_W-1:0]          dn_data,
   output logic [ADDR_W-1:0]          dn_wd,
   output logic                       dn_wreg,
   output logic [$clog2(DEPTH+2)-1:0] occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int PW    = DATA_W + ADDR_W + 1;
   localparam int OCC_W = $clog2(DEPTH + 2);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    pay_q [DEPTH];
   logic [PW-1:0]    pay_d [DEPTH];
   logic [DEPTH:0]   adv_s;
   logic [PW-1:0]    up_pay_s, in_pay_s;
   logic             in_valid_s, up_ready_s, skid_valid_s;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   assign up_pay_s = {up_wreg, up_wd, up_data};

   // Slot k can take new content when it is empty or its occupant moves on this cycle.
   always_comb begin
      adv_s[DEPTH] = dn_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv_s[k] = !valid_q[k] || adv_s[k+1];
      end
   end

`ifdef PIPE_SKID_BUF_EN
   logic          skid_valid_q, skid_valid_d;
   logic [PW-1:0] skid_pay_q, skid_pay_d;

   // Skid holds a beat slot 0 could not take; it always feeds slot 0 ahead of new input.
   always_comb begin
      up_ready_s   = !flush && !skid_valid_q;
      in_valid_s   = skid_valid_q || (up_valid && up_ready_s);
      in_pay_s     = skid_valid_q ? skid_pay_q : up_pay_s;
      skid_valid_d = skid_valid_q;
      skid_pay_d   = skid_pay_q;
      if (flush) begin
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         skid_valid_d = !adv_s[0];
      end else if (up_valid && up_ready_s && !adv_s[0]) begin
         skid_valid_d = 1'b1;
         skid_pay_d   = up_pay_s;
      end else begin
         skid_valid_d = 1'b0;
      end
   end

   // Skid register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_valid_q <= 1'b0;
         skid_pay_q   <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_pay_q   <= skid_pay_d;
      end
   end

   assign skid_valid_s = skid_valid_d;
`else
   // Without a skid, acceptance follows the advance chain straight from dn_ready.
   always_comb begin
      up_ready_s = !flush && adv_s[0];
      in_valid_s = up_valid && up_ready_s;
      in_pay_s   = up_pay_s;
   end

   assign skid_valid_s = 1'b0;
`endif

   // Slot shifting: a loading slot copies its predecessor; flush empties every slot.
   always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      if (adv_s[0]) begin
         valid_d[0] = in_valid_s;
         pay_d[0]   = in_pay_s;
      end else begin
         valid_d[0] = valid_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (adv_s[k]) begin
            valid_d[k] = valid_q[k-1];
            pay_d[k]   = pay_q[k-1];
         end else begin
            valid_d[k] = valid_q[k];
         end
      end
      if (flush) begin
         valid_d = '0;
      end else begin
         valid_d = valid_d;
      end
   end

   // Next occupancy and saturating stall counter.
   always_comb begin
      occ_d = OCC_W'(skid_valid_s);
      for (int k = 0; k < DEPTH; k++) begin
         occ_d = occ_d + OCC_W'(valid_d[k]);
      end
      if (valid_q[DEPTH-1] && !dn_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1'b1);
      end else begin
         stall_d = stall_q;
      end
   end

   // Chain state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         occ_q   <= '0;
         stall_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            pay_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         stall_q <= stall_d;
         for (int k = 0; k < DEPTH; k++) begin
            pay_q[k] <= pay_d[k];
         end
      end
   end

   assign up_ready                   = up_ready_s;
   assign dn_valid                   = valid_q[DEPTH-1];
   assign {dn_wreg, dn_wd, dn_data}  = valid_q[DEPTH-1] ? pay_q[DEPTH-1] : {PW{1'b0}};
   assign occupancy                  = occ_q;
   assign stall_cnt                  = stall_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: queue-of-entries model plus directed literal checks.
module tb_pipe_stage_chain;

   localparam int D  = 2;
   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst, flush, up_valid, up_ready, up_wreg, dn_valid, dn_ready, dn_wreg;
   logic [31:0] up_data, dn_data;
   logic [4:0]  up_wd, dn_wd;
   logic [1:0]  occupancy;
   logic [3:0]  stall_cnt;

   logic        b_flush, b_uv, b_ur, b_wreg, b_dv, b_dr, b_dn_wreg;
   logic [31:0] b_data, b_dn_data;
   logic [4:0]  b_wd, b_dn_wd;
   logic [2:0]  b_occ;
   logic [3:0]  b_stall;

   pipe_stage_chain #(.DATA_W(32), .ADDR_W(5), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready),
      .up_data(up_data), .up_wd(up_wd), .up_wreg(up_wreg), .dn_valid(dn_valid),
      .dn_ready(dn_ready), .dn_data(dn_data), .dn_wd(dn_wd), .dn_wreg(dn_wreg),
      .occupancy(occupancy), .stall_cnt(stall_cnt));

   pipe_stage_chain #(.DATA_W(32), .ADDR_W(5), .DEPTH(3), .CNT_W(CW)) dut3 (
      .clk(clk), .rst(rst), .flush(b_flush), .up_valid(b_uv), .up_ready(b_ur),
      .up_data(b_data), .up_wd(b_wd), .up_wreg(b_wreg), .dn_valid(b_dv),
      .dn_ready(b_dr), .dn_data(b_dn_data), .dn_wd(b_dn_wd), .dn_wreg(b_dn_wreg),
      .occupancy(b_occ), .stall_cnt(b_stall));

   always #5 clk = ~clk;

   typedef struct {
      int          pos;
      logic [31:0] data;
      logic [4:0]  wd;
      logic        wreg;
   } ent_t;

   // Model: entries oldest-first, each with a position; D-1 is the head.
   ent_t        mq[$];
   bit          sk_v;
`ifdef PIPE_SKID_BUF_EN
   ent_t        sk;
`endif
   int          m_stall;
   int          n_cmp, n_err;
   logic [31:0] recv[$];
   int          exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void m_shift(input bit dr);
      if (mq.size() > 0 && mq[0].pos == D - 1 && dr) mq.delete(0);
      for (int i = 0; i < mq.size(); i++) begin
         int lim;
         lim = (i == 0) ? D - 1 : mq[i-1].pos - 1;
         if (mq[i].pos < lim) mq[i].pos = mq[i].pos + 1;
      end
   endfunction

   function automatic bit m_up_ready(input bit dr, input bit fl);
`ifdef PIPE_SKID_BUF_EN
      return !fl && !sk_v;
`else
      ent_t sv[$];
      bit   r;
      sv = mq;
      m_shift(dr);
      r  = !fl && (mq.size() == 0 || mq[mq.size()-1].pos > 0);
      mq = sv;
      return r;
`endif
   endfunction

   function automatic void m_step(input bit uv, input ent_t e, input bit dr, input bit fl, input bit ur);
      bit free0, acc;
      if (mq.size() > 0 && mq[0].pos == D - 1 && !dr && m_stall < (1 << CW) - 1) m_stall++;
      if (fl) begin
         mq.delete();
         sk_v = 1'b0;
         return;
      end
      m_shift(dr);
      free0 = (mq.size() == 0) || (mq[mq.size()-1].pos > 0);
      acc   = uv && ur;
`ifdef PIPE_SKID_BUF_EN
      if (free0 && sk_v) begin
         mq.push_back(sk);
         sk_v = 1'b0;
      end else if (free0 && acc) begin
         mq.push_back(e);
      end else if (acc) begin
         sk   = e;
         sk_v = 1'b1;
      end
`else
      if (acc && free0) mq.push_back(e);
`endif
   endfunction

   function automatic void m_reset();
      mq.delete();
      sk_v    = 1'b0;
      m_stall = 0;
   endfunction

   task automatic compare_outputs();
      bit ev;
      ev = (mq.size() > 0) && (mq[0].pos == D - 1);
      chk("dn_valid", 64'(dn_valid), 64'(ev));
      if (ev) begin
         chk("dn_data", 64'(dn_data), 64'(mq[0].data));
         chk("dn_wd",   64'(dn_wd),   64'(mq[0].wd));
         chk("dn_wreg", 64'(dn_wreg), 64'(mq[0].wreg));
      end else begin
         chk("dn_data_bubble", 64'({dn_wreg, dn_wd, dn_data}), 64'd0);
      end
      chk("occupancy", 64'(occupancy), 64'(mq.size() + int'(sk_v)));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
   endtask

   task automatic tick(input bit uv, input logic [31:0] d, input logic [4:0] wd,
                       input bit wr, input bit dr, input bit fl);
      bit   ur;
      ent_t e;
      up_valid = uv; up_data = d; up_wd = wd; up_wreg = wr; dn_ready = dr; flush = fl;
      #1;
      ur = m_up_ready(dr, fl);
      chk("up_ready", 64'(up_ready), 64'(ur));
      @(posedge clk);
      e.pos = 0; e.data = d; e.wd = wd; e.wreg = wr;
      m_step(uv, e, dr, fl, ur);
      #1;
      compare_outputs();
      if (dn_valid) recv.push_back(dn_data);
   endtask

   task automatic chk_recv(input string nm);
      chk({nm, "_count"}, 64'(recv.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < recv.size(); i++)
         chk({nm, "_order"}, 64'(recv[i]), 64'(exp_q[i]));
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; up_valid = 1'b0; up_data = 32'd0; up_wd = 5'd0;
      up_wreg = 1'b0; dn_ready = 1'b0;
      b_flush = 1'b0; b_uv = 1'b0; b_data = 32'd0; b_wd = 5'd0; b_wreg = 1'b0; b_dr = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dn_valid", 64'(dn_valid), 64'd0);
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_stall", 64'(stall_cnt), 64'd0);
      compare_outputs();
      @(negedge clk) rst = 1'b1;

      // Stream 1..8 with dn_ready high.
      recv.delete();
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, 32'(i), 5'(i), 1'b1, 1'b1, 1'b0);
         if (i == 1) chk("lat_first_edge_dv", 64'(dn_valid), 64'd0);
         if (i == 2) chk("lat_second_edge_data", 64'(dn_data), 64'd1);
      end
      chk("stream_rate", 64'(recv.size()), 64'd7);
      repeat (3) tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
      chk_recv("stream");

      // Backpressure, stall counting and saturation.
      tick(1'b1, 32'd11, 5'd11, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 32'd12, 5'd12, 1'b1, 1'b0, 1'b0);
      repeat (5) tick(1'b1, 32'd13, 5'd13, 1'b1, 1'b0, 1'b0);
      chk("bp_stall5", 64'(stall_cnt), 64'd5);
      chk("bp_up_ready", 64'(up_ready), 64'd0);
      chk("bp_head", 64'(dn_data), 64'd11);
`ifdef PIPE_SKID_BUF_EN
      chk("bp_occ", 64'(occupancy), 64'd3);
`else
      chk("bp_occ", 64'(occupancy), 64'd2);
`endif
      repeat (12) tick(1'b1, 32'd13, 5'd13, 1'b1, 1'b0, 1'b0);
      chk("stall_saturate", 64'(stall_cnt), 64'd15);
      recv.delete();
      repeat (5) tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_SKID_BUF_EN
      exp_q = '{12, 13};
`else
      exp_q = '{12};
`endif
      chk_recv("drain");

      // Asynchronous reset with two entries in flight.
      tick(1'b1, 32'd21, 5'd21, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 32'd22, 5'd22, 1'b1, 1'b0, 1'b0);
      chk("prereset_stall", 64'(stall_cnt), 64'd15);
      chk("prereset_occ", 64'(occupancy), 64'd2);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_dv", 64'(dn_valid), 64'd0);
      chk("async_rst_wreg", 64'(dn_wreg), 64'd0);
      chk("async_rst_occ", 64'(occupancy), 64'd0);
      chk("async_rst_stall", 64'(stall_cnt), 64'd0);
      m_reset();
      @(negedge clk) rst = 1'b1;

      // Flush of a full chain with a concurrent beat.
      tick(1'b1, 32'd31, 5'd1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 32'd32, 5'd2, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("preflush_occ", 64'(occupancy), 64'd2);
      tick(1'b1, 32'd33, 5'd3, 1'b1, 1'b1, 1'b1);
      chk("flush_dv", 64'(dn_valid), 64'd0);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_stall_kept", 64'(stall_cnt), 64'd1);
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("flush_beat_dropped", 64'(dn_valid), 64'd0);

      // Bubble compression on the DEPTH=3 instance.
      b_uv = 1'b1; b_data = 32'hA; b_wd = 5'd3; b_wreg = 1'b1; b_dr = 1'b0;
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      b_uv = 1'b0;
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      b_uv = 1'b1; b_data = 32'hB; b_wd = 5'd4;
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      b_uv = 1'b0;
      repeat (2) tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("bubble_occ", 64'(b_occ), 64'd2);
      chk("bubble_up_ready", 64'(b_ur), 64'd1);
      chk("bubble_head_dv", 64'(b_dv), 64'd1);
      chk("bubble_head_data", 64'(b_dn_data), 64'hA);
      chk("bubble_head_wd", 64'(b_dn_wd), 64'd3);
      chk("bubble_head_wreg", 64'(b_dn_wreg), 64'd1);
      chk("bubble_stall", 64'(b_stall), 64'd2);
      b_dr = 1'b1;
      tick(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("bubble_next_data", 64'(b_dn_data), 64'hB);
      chk("bubble_next_wd", 64'(b_dn_wd), 64'd4);
      chk("bubble_next_occ", 64'(b_occ), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
